// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word-aligned requests to instruction memory and
// presents fetched instructions to the IF/ID register through a buffer plus one-entry skid.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] out_pc,
    output logic [31:0] out_instruction,
    output logic        out_valid
);

    typedef enum logic {FETCH, DRAIN} state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] drain_addr_q;
    logic        outst_q;
    logic        buf_valid_q;
    logic [31:0] buf_pc_q;
    logic [31:0] buf_inst_q;
    logic        skid_valid_q;
    logic [31:0] skid_pc_q;
    logic [31:0] skid_inst_q;

    logic        accept;
    logic        resp_keep;
    logic [31:0] resp_pc;
    logic [31:0] redirect_pc_d;
    logic [1:0]  unused_redirect_lo;

    // A request that has been raised but not accepted must be held, so it also keeps imem_req high.
    assign imem_req  = !rst && ((state_q == DRAIN) || !skid_valid_q || outst_q);
    assign imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;
    assign accept    = imem_req && imem_ready;
    assign resp_keep = accept && (state_q == FETCH) && !redirect;
    assign resp_pc   = imem_addr + 32'd4;

    assign redirect_pc_d      = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lo = redirect_pc[1:0];

    assign out_pc          = buf_pc_q;
    assign out_instruction = buf_inst_q;
    assign out_valid       = buf_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= {RESET_PC[31:2], 2'b00};
            outst_q      <= 1'b0;
            buf_valid_q  <= 1'b0;
            buf_pc_q     <= 32'h0;
            buf_inst_q   <= NOP;
            skid_valid_q <= 1'b0;
        end else begin
            outst_q <= imem_req && !imem_ready;
            if (redirect) begin
                buf_valid_q  <= 1'b0;
                buf_inst_q   <= NOP;
                skid_valid_q <= 1'b0;
                pc_q         <= redirect_pc_d;
                // A pending request cannot be withdrawn; remember its address and drain it.
                if (state_q == FETCH && imem_req && !imem_ready) begin
                    state_q      <= DRAIN;
                    drain_addr_q <= pc_q;
                end else if (state_q == DRAIN && imem_ready) begin
                    state_q <= FETCH;
                end
            end else begin
                if (state_q == DRAIN) begin
                    if (imem_ready) begin
                        state_q <= FETCH;
                    end
                end else if (accept) begin
                    pc_q <= pc_q + 32'd4;
                end

                if (!stall) begin
                    if (skid_valid_q) begin
                        buf_valid_q  <= 1'b1;
                        buf_pc_q     <= skid_pc_q;
                        buf_inst_q   <= skid_inst_q;
                        skid_valid_q <= resp_keep;
                        if (resp_keep) begin
                            skid_pc_q   <= resp_pc;
                            skid_inst_q <= imem_rdata;
                        end
                    end else if (resp_keep) begin
                        buf_valid_q <= 1'b1;
                        buf_pc_q    <= resp_pc;
                        buf_inst_q  <= imem_rdata;
                    end else begin
                        buf_valid_q <= 1'b0;
                        buf_inst_q  <= NOP;
                    end
                end else if (resp_keep) begin
                    if (!buf_valid_q) begin
                        buf_valid_q <= 1'b1;
                        buf_pc_q    <= resp_pc;
                        buf_inst_q  <= imem_rdata;
                    end else begin
                        skid_valid_q <= 1'b1;
                        skid_pc_q    <= resp_pc;
                        skid_inst_q  <= imem_rdata;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus a randomized run checked against
// a program-order model of the expected instruction stream.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_I   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] out_pc;
    logic [31:0] out_instruction;
    logic        out_valid;

    int checks = 0;
    int errors = 0;

    int wait_cnt = 0;
    int cur_wait = 0;
    int wait_fixed = 0;
    logic rnd_mode = 1'b0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RST_PC), .NOP(NOP_I)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .out_pc(out_pc), .out_instruction(out_instruction), .out_valid(out_valid)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    // Memory: answers each request after cur_wait cycles of holding it.
    assign imem_ready = imem_req && (wait_cnt >= cur_wait);
    assign imem_rdata = inst_of(imem_addr);

    always @(posedge clk) begin
        if (rst || !imem_req || imem_ready) begin
            wait_cnt <= 0;
            cur_wait <= rnd_mode ? int'($urandom_range(0, 3)) : wait_fixed;
        end else begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
        @(posedge clk); #1;
        rst = r; stall = s; redirect = rd; redirect_pc = rpc;
        @(negedge clk);
    endtask

    task automatic reset_dut(input int waits, input logic rnd);
        @(posedge clk); #1;
        wait_fixed = waits; rnd_mode = rnd;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
    endtask

    logic [31:0] exp_addr;
    logic [31:0] prev_addr, prev_pc, prev_inst;
    logic        prev_req, prev_ready, prev_stall, prev_redir, prev_valid;
    logic        s, rd, found;
    logic [31:0] rpc;
    int          consumed;

    initial begin
        // Reset state and zero-wait streaming
        reset_dut(0, 1'b0);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_inst", out_instruction, NOP_I);
        chk("rst_pc", out_pc, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
            chk("zw_req", {31'b0, imem_req}, 32'd1);
            chk("zw_addr", imem_addr, RST_PC + 32'(4 * i));
            chk("zw_valid", {31'b0, out_valid}, (i == 0) ? 32'd0 : 32'd1);
            if (i > 0) begin
                chk("zw_pc", out_pc, RST_PC + 32'(4 * i));
                chk("zw_inst", out_instruction, inst_of(RST_PC + 32'(4 * (i - 1))));
            end
        end

        // Two wait states per fetch
        reset_dut(2, 1'b0);
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
            chk("ws_addr", imem_addr, RST_PC + 32'(4 * (i / 3)));
            chk("ws_valid", {31'b0, out_valid}, (i > 0 && i % 3 == 0) ? 32'd1 : 32'd0);
            chk("ws_inst", out_instruction,
                (i > 0 && i % 3 == 0) ? inst_of(RST_PC + 32'(4 * (i / 3 - 1))) : NOP_I);
        end

        // Stall for three cycles: skid fills, request drops, then in-order drain
        reset_dut(0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("st_c1_pc", out_pc, 32'd4);
        chk("st_c1_addr", imem_addr, 32'd4);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, (i < 2), 1'b0, 32'h0);
            chk("st_hold_pc", out_pc, 32'd4);
            chk("st_hold_inst", out_instruction, inst_of(32'd0));
            chk("st_hold_valid", {31'b0, out_valid}, 32'd1);
            chk("st_hold_req", {31'b0, imem_req}, 32'd0);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("st_drain_pc", out_pc, 32'd8);
        chk("st_drain_inst", out_instruction, inst_of(32'd4));
        chk("st_drain_addr", imem_addr, 32'd8);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("st_next_pc", out_pc, 32'd12);
        chk("st_next_inst", out_instruction, inst_of(32'd8));

        // Redirect while the request to 8 is waiting
        reset_dut(2, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("rd_pending_addr", imem_addr, 32'd8);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0103);
        chk("rd_pending_addr2", imem_addr, 32'd8);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("rd_drain_req", {31'b0, imem_req}, 32'd1);
        chk("rd_drain_addr", imem_addr, 32'd8);
        chk("rd_drain_valid", {31'b0, out_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
            chk("rd_new_addr", imem_addr, 32'h0000_0100);
            chk("rd_wait_valid", {31'b0, out_valid}, 32'd0);
            chk("rd_wait_inst", out_instruction, NOP_I);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("rd_ret_valid", {31'b0, out_valid}, 32'd1);
        chk("rd_ret_pc", out_pc, 32'h0000_0104);
        chk("rd_ret_inst", out_instruction, inst_of(32'h0000_0100));

        // Redirect and stall on the same edge with a full skid
        reset_dut(0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0200);
        chk("rs_skid_full_req", {31'b0, imem_req}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("rs_valid", {31'b0, out_valid}, 32'd0);
        chk("rs_inst", out_instruction, NOP_I);
        chk("rs_addr", imem_addr, 32'h0000_0200);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("rs_ret_pc", out_pc, 32'h0000_0204);
        chk("rs_ret_inst", out_instruction, inst_of(32'h0000_0200));

        // Reset while a request to 0xFFFF_FFFC is outstanding
        reset_dut(3, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
            if (imem_req && imem_addr == 32'hFFFF_FFFC) found = 1'b1;
        end
        chk("rm_found", {31'b0, found}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("rm_hold_req", {31'b0, imem_req}, 32'd1);
        chk("rm_hold_addr", imem_addr, 32'hFFFF_FFFC);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0040);
        chk("rm_rst_req", {31'b0, imem_req}, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("rm_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rm_rst_inst", out_instruction, NOP_I);
        chk("rm_rst_pc", out_pc, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("rm_post_req", {31'b0, imem_req}, 32'd1);
        chk("rm_post_addr", imem_addr, RST_PC);

        // Address wrap
        reset_dut(0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("wr_addr0", imem_addr, 32'hFFFF_FFFC);
        chk("wr_valid0", {31'b0, out_valid}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("wr_addr1", imem_addr, 32'h0);
        chk("wr_pc1", out_pc, 32'h0);
        chk("wr_inst1", out_instruction, inst_of(32'hFFFF_FFFC));
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("wr_pc2", out_pc, 32'h4);
        chk("wr_inst2", out_instruction, inst_of(32'h0));

        // Randomized waits, stalls and redirects against the program-order stream
        reset_dut(0, 1'b1);
        exp_addr = RST_PC;
        consumed = 0;
        prev_req = 1'b0; prev_ready = 1'b0; prev_stall = 1'b0; prev_redir = 1'b0;
        prev_valid = 1'b0; prev_addr = 32'h0; prev_pc = 32'h0; prev_inst = 32'h0;
        for (int i = 0; i < 3000; i++) begin
            s   = ($urandom_range(0, 99) < 30);
            rd  = ($urandom_range(0, 99) < 3);
            rpc = $urandom;
            step(1'b0, s, rd, rpc);
            if (prev_req && !prev_ready) begin
                chk("rnd_req_held", {31'b0, imem_req}, 32'd1);
                chk("rnd_addr_held", imem_addr, prev_addr);
            end
            if (prev_stall && !prev_redir && prev_valid) begin
                chk("rnd_stall_pc", out_pc, prev_pc);
                chk("rnd_stall_inst", out_instruction, prev_inst);
                chk("rnd_stall_valid", {31'b0, out_valid}, 32'd1);
            end
            if (imem_req) chk("rnd_addr_align", {30'b0, imem_addr[1:0]}, 32'd0);
            if (!out_valid) chk("rnd_nop", out_instruction, NOP_I);
            if (out_valid && !stall && !redirect) begin
                chk("rnd_pc", out_pc, exp_addr + 32'd4);
                chk("rnd_inst", out_instruction, inst_of(exp_addr));
                exp_addr = exp_addr + 32'd4;
                consumed++;
            end
            if (redirect) exp_addr = {redirect_pc[31:2], 2'b00};
            prev_req = imem_req; prev_ready = imem_ready; prev_addr = imem_addr;
            prev_stall = stall; prev_redir = redirect; prev_valid = out_valid;
            prev_pc = out_pc; prev_inst = out_instruction;
        end
        chk("rnd_progress", {31'b0, (consumed > 200)}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
